mdu_iter: RTL and testbench

- Iterative multiply/divide unit that implements the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits next to the combinational ALU in the execute stage; the pipeline stalls on in_ready/out_valid.
- Processes one result bit per cycle using radix-2 shift-add (multiply) and restoring (divide) datapaths.
- Width is parametrised; valid/ready handshake on both sides.

---
 rtl/mdu_iter_pkg.sv | 23 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mdu_iter.sv | 143 ++++++++++++++
 tb/tb_mdu_iter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M funct3 op codes
// and FSM states.
package mdu_iter_pkg;

    localparam int MDU_FUNC_BIT = 3;

    localparam logic [MDU_FUNC_BIT-1:0] OP_MUL    = 3'd0;
    localparam logic [MDU_FUNC_BIT-1:0] OP_MULH   = 3'd1;
    localparam logic [MDU_FUNC_BIT-1:0] OP_MULHSU = 3'd2;
    localparam logic [MDU_FUNC_BIT-1:0] OP_MULHU  = 3'd3;
    localparam logic [MDU_FUNC_BIT-1:0] OP_DIV    = 3'd4;
    localparam logic [MDU_FUNC_BIT-1:0] OP_DIVU   = 3'd5;
    localparam logic [MDU_FUNC_BIT-1:0] OP_REM    = 3'd6;
    localparam logic [MDU_FUNC_BIT-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, modulo 2^W (combinational).
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_ZERO_SKIP_EN: zero-operand cases take the one-cycle fast path.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MDU_FUNC_BIT-1:0] in_op,
    input  logic [XLEN-1:0]         in_a,
    input  logic [XLEN-1:0]         in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data
);

    mdu_state_e              r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [MDU_FUNC_BIT-1:0] r_op;
    logic                    r_neg;
    logic                    r_fast;
    logic [XLEN-1:0]         r_fast_val;
    logic [XLEN-1:0]         r_m;
    logic [2*XLEN-1:0]       r_acc;
    logic [XLEN-1:0]         r_out;

    logic                    w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
    logic [XLEN-1:0]         w_mag_a, w_mag_b;
    logic                    w_ovf, w_fast;
    logic [XLEN-1:0]         w_fast_val;
    logic [XLEN:0]           w_mul_sum, w_div_rem, w_div_diff;
    logic [2*XLEN-1:0]       w_mul_next, w_div_next, w_prod;
    logic [XLEN-1:0]         w_div_sel, w_div_res, w_result;

    assign w_accept   = (r_state == IDLE) && in_valid && !flush;
    assign w_is_div   = in_op[2];
    assign w_a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                        (in_op == OP_DIV) || (in_op == OP_REM);
    assign w_b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    assign w_sa       = w_a_signed && in_a[XLEN-1];
    assign w_sb       = w_b_signed && in_b[XLEN-1];
    assign w_neg      = (in_op == OP_REM) ? w_sa : (w_sa ^ w_sb);
    assign w_ovf      = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                        (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);

    mdu_negate #(.W(XLEN)) u_neg_a (.i_neg(w_sa), .i_val(in_a), .o_val(w_mag_a));
    mdu_negate #(.W(XLEN)) u_neg_b (.i_neg(w_sb), .i_val(in_b), .o_val(w_mag_b));

    always_comb begin
        w_fast     = 1'b0;
        w_fast_val = '0;
        if (w_is_div && (in_b == '0)) begin
            w_fast     = 1'b1;
            w_fast_val = in_op[1] ? in_a : '1;
        end else if (w_ovf) begin
            w_fast     = 1'b1;
            w_fast_val = in_op[1] ? '0 : in_a;
        end
`ifdef MDU_ZERO_SKIP_EN
        else if ((!w_is_div && ((in_a == '0) || (in_b == '0))) ||
                 (w_is_div && (in_a == '0))) begin
            w_fast     = 1'b1;
            w_fast_val = '0;
        end
`endif
    end

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, quotient bits enter at the bottom.
    assign w_div_rem  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff = w_div_rem - {1'b0, r_m};
    assign w_div_next = w_div_diff[XLEN] ? {w_div_rem[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // The full product is negated so MULH* high words stay exact.
    mdu_negate #(.W(2*XLEN)) u_neg_prod (.i_neg(r_neg), .i_val(r_acc), .o_val(w_prod));

    assign w_div_sel = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    mdu_negate #(.W(XLEN)) u_neg_div (.i_neg(r_neg), .i_val(w_div_sel), .o_val(w_div_res));

    assign w_result = r_fast ? r_fast_val :
                      r_op[2] ? w_div_res :
                      (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_next = w_fast ? FIX : CALC;
            CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_fast     <= 1'b0;
            r_fast_val <= '0;
            r_m        <= '0;
            r_acc      <= '0;
            r_out      <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_op       <= in_op;
            r_neg      <= w_neg;
            r_fast     <= w_fast;
            r_fast_val <= w_fast_val;
            r_m        <= w_is_div ? w_mag_b : w_mag_a;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
        end else if ((r_state == FIX) && !flush) begin
            r_out <= w_result;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M vectors plus randomized ops vs a
// 64-bit arithmetic reference model.
module tb_mdu_iter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_ZERO_SKIP_EN
        if (!op[2] && (a == 0 || b == 0)) return 1;
        if (op[2] && a == 0) return 1;
`endif
        return 33;
    endfunction

    // Drives one request from IDLE, reports result, latency after the accept edge and
    // whether in_ready stayed low while busy; completes the output handshake.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic rdy_low);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                   3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as   [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd2, 32'd2, 32'd7, 32'd7,
                                   32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        logic        rdy_low;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, rdy_low);
            n_checks++;
            if (res !== exps[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_data op=%0d got=%h want=%h", i, ops[i], res, exps[i]);
            end
            n_checks++;
            if (lat != lats[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, lats[i]);
            end
            n_checks++;
            if (rdy_low !== 1'b1) begin
                n_fail++; $display("FAIL directed_%0d_in_ready_busy got=high want=low", i);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        logic        rdy_low;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = 32'h0;
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(op, a, b, res, lat, rdy_low);
            n_checks++;
            if (res !== ref_result(op, a, b)) begin
                n_fail++;
                $display("FAIL random_%0d_data op=%0d a=%h b=%h got=%h want=%h",
                         i, op, a, b, res, ref_result(op, a, b));
            end
            n_checks++;
            if (lat != exp_lat(op, a, b)) begin
                n_fail++;
                $display("FAIL random_%0d_latency op=%0d got=%0d want=%0d",
                         i, op, lat, exp_lat(op, a, b));
            end
        end
    endtask

    task automatic test_hold();
        int wait_cnt = 0;
        in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (!out_valid && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++; $display("FAIL hold_reach_done got=timeout want=out_valid");
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_data !== 32'd14 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d got data=%h rdy=%b vld=%b want data=0000000e rdy=0 vld=1",
                         i, out_data, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic        seen = 1'b0;
        logic [31:0] res;
        int          lat;
        logic        rdy_low;
        in_op = 3'd5; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_result got=out_valid_seen want=none");
        end
        in_op = 3'd0; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_beats_valid got rdy=%b want=1", in_ready);
        end
        do_op(3'd0, 32'd3, 32'd4, res, lat, rdy_low);
        n_checks++;
        if (res !== 32'd12 || lat != 33) begin
            n_fail++;
            $display("FAIL flush_then_mul got data=%h lat=%0d want data=0000000c lat=33", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        logic        rdy_low;
        in_op = 3'd0; in_a = 32'd5; in_b = 32'd6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got vld=%b rdy=%b data=%h want vld=0 rdy=1 data=0",
                     out_valid, in_ready, out_data);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(3'd0, 32'd5, 32'd6, res, lat, rdy_low);
        n_checks++;
        if (res !== 32'd30 || lat != 33) begin
            n_fail++;
            $display("FAIL post_reset_mul got data=%h lat=%0d want data=0000001e lat=33", res, lat);
        end
    endtask

    task automatic test_zero_skip();
        logic [31:0] res;
        int          lat;
        logic        rdy_low;
        do_op(3'd0, 32'h0, 32'h1234, res, lat, rdy_low);
        n_checks++;
        if (res !== 32'h0 || lat != exp_lat(3'd0, 32'h0, 32'h1234)) begin
            n_fail++;
            $display("FAIL zero_skip_mul got data=%h lat=%0d want data=0 lat=%0d",
                     res, lat, exp_lat(3'd0, 32'h0, 32'h1234));
        end
        do_op(3'd5, 32'h0, 32'd5, res, lat, rdy_low);
        n_checks++;
        if (res !== 32'h0 || lat != exp_lat(3'd5, 32'h0, 32'd5)) begin
            n_fail++;
            $display("FAIL zero_skip_div got data=%h lat=%0d want data=0 lat=%0d",
                     res, lat, exp_lat(3'd5, 32'h0, 32'd5));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_async_reset();
        test_zero_skip();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
